// File: rtl/matrix_stream_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matrix_stream_loader: packs a valid/ready element stream into a         |
// | double-banked ROWS x COLS matrix bus (fill bank + held output bank).     |
// | Option: MATRIX_LOADER_COLMAJOR_EN selects column-major input ordering.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matrix_stream_loader #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  input  logic                              in_last,
  output logic                              in_ready,
  output logic [ROWS*COLS*DATA_WIDTH-1:0]   out_mat,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              err_early,
  output logic                              err_late
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N - 1);

  if (FRACT_WIDTH < 0 || FRACT_WIDTH > DATA_WIDTH) begin : g_bad_fract
    $error("FRACT_WIDTH must lie within DATA_WIDTH");
  end

  // Fill bank is kept in stream order; the layout mapping happens on the copy.
  logic [DATA_WIDTH-1:0]       r_fill      [N];
  logic [DATA_WIDTH-1:0]       w_next_fill [N];
  logic [N*DATA_WIDTH-1:0]     w_mat;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_fill_full;
  logic                        r_out_valid;
  logic [N*DATA_WIDTH-1:0]     r_out_mat;
  logic                        r_err_early;
  logic                        r_err_late;
  logic                        w_accept;
  logic                        w_at_last;
  logic                        w_close;
  logic                        w_out_hs;
  logic                        w_out_free;

  assign w_accept   = in_valid && !r_fill_full;
  assign w_at_last  = (r_idx == c_idx_last);
  assign w_close    = w_accept && (in_last || w_at_last);
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || out_ready;

  // Early close zeroes every slot after the closing element.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_next_fill[k] = r_fill[k];
      if (w_accept) begin
        if (k == int'(r_idx)) begin
          w_next_fill[k] = in_data;
        end else if (in_last && (k > int'(r_idx))) begin
          w_next_fill[k] = '0;
        end
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_map
`ifdef MATRIX_LOADER_COLMAJOR_EN
    localparam int ROW = k % ROWS;
    localparam int COL = k / ROWS;
`else
    localparam int ROW = k / COLS;
    localparam int COL = k % COLS;
`endif
    assign w_mat[(ROW*COLS+COL)*DATA_WIDTH +: DATA_WIDTH] = w_next_fill[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        r_fill[k] <= '0;
      end
      r_idx <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < N; k++) begin
        r_fill[k] <= w_next_fill[k];
      end
      r_idx <= w_close ? '0 : r_idx + 1'b1;
    end
  end

  // While the fill bank is full no element is accepted, so w_mat equals the held fill bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_mat   <= '0;
      r_out_valid <= 1'b0;
      r_fill_full <= 1'b0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      r_err_early <= w_close && in_last && !w_at_last;
      r_err_late  <= w_accept && w_at_last && !in_last;
      if (w_close && w_out_free) begin
        r_out_mat   <= w_mat;
        r_out_valid <= 1'b1;
      end else if (r_fill_full && w_out_hs) begin
        r_out_mat   <= w_mat;
        r_out_valid <= 1'b1;
        r_fill_full <= 1'b0;
      end else if (w_close) begin
        r_fill_full <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = !r_fill_full;
  assign out_mat   = r_out_mat;
  assign out_valid = r_out_valid;
  assign err_early = r_err_early;
  assign err_late  = r_err_late;

endmodule
`default_nettype wire
